mask_st_seq: RTL and testbench
==============================

MASK_ST_SEQ -- requirements
Module: mask_st_seq

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, SHALL select the mask register index width (32 registers).
REQ-002 Parameter DATA_WIDTH, default 64, SHALL set the beat width in bits; DW_B = DATA_WIDTH/8 SHALL be derived.
REQ-003 Parameter OFF_BITS, default 8, SHALL set the beat offset width within one register.
REQ-004 Ports, name, direction, width and meaning, SHALL be:
  clk  in  1  sole clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  req_valid  in  1  store request offered.
  req_ready  out  1  request accepted when high with req_valid.
  req_addr  in  ADDR_WIDTH  source mask register.
  req_len  in  OFF_BITS+1  beat count, 0..2^OFF_BITS.
  req_last_be  in  DW_B  byte enable of the final beat.
  st_en  out  DW_B  read enable to the mask file store port.
  st_addr  out  ADDR_WIDTH  store-port register index.
  st_off  out  OFF_BITS  store-port beat offset.
  st_data_out  in  DATA_WIDTH  mask file read data, valid one cycle after st_en.
  out_valid  out  1  beat available.
  out_ready  in  1  consumer accepts beat.
  out_data  out  DATA_WIDTH  beat data.
  out_be  out  DW_B  beat byte enable.
  out_last  out  1  final beat of the request.
  done  out  1  one-cycle pulse, request fully drained.

Function
REQ-005 States SHALL be IDLE, RUN and DRAIN; req_ready SHALL be high only in IDLE.
REQ-006 On accept with req_len>0: latch addr, len and last_be; set the offset counter to 0; go to RUN.
REQ-007 On accept with req_len==0: issue no reads; pulse done the next cycle; remain in IDLE.
REQ-008 In RUN, one read SHALL issue per cycle when (FIFO occupancy + reads in flight) < 2.
  - Each read drives st_en nonzero, st_addr = latched addr, st_off = counter.
  - st_en SHALL be all-ones, or last_be on the final beat.
  - last_be==0 on the final beat SHALL be replaced by all-ones so the read still fires.
REQ-009 When no read issues, st_en SHALL be 0; st_addr and st_off are don't-care.
REQ-010 Read data SHALL be captured from st_data_out exactly one cycle after issue into a 2-entry FIFO, with be and last tagged at issue time.
REQ-011 The FIFO head SHALL drive out_valid, out_data, out_be and out_last; a beat pops on out_valid && out_ready.
  - Push and pop in the same cycle SHALL both take effect.
  - No beat SHALL be dropped or duplicated under any out_ready pattern.
REQ-012 After the final read issues, RUN SHALL go to DRAIN.
REQ-013 When the out_last beat pops: done pulses that same cycle and the state returns to IDLE.
REQ-014 Offsets SHALL run 0..len-1; len==2^OFF_BITS SHALL reach offset 2^OFF_BITS-1 without wrap or an extra beat.
REQ-015 Throughput SHALL be one beat per cycle with out_ready held high; first out_valid SHALL rise 2 cycles after accept.

Reset
REQ-016 While rst_n is low, all outputs SHALL reset asynchronously to these values:
  - State IDLE.
  - FIFO empty, in-flight flag cleared.
  - out_valid=0, done=0, st_en=0, out_data=0, out_be=0, out_last=0, st_addr=0, st_off=0.
  - req_ready=1 once rst_n is high.
REQ-017 Reset mid-request SHALL abandon the request; no done pulse SHALL follow.

Structure
REQ-018 The state enum and the FIFO depth constant (2) SHALL live in a shared package, mask_pkg.
REQ-019 The 2-entry FIFO SHALL be a sub-module named mask_beat_fifo (data+be+last, push/pop, full/empty).

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  - addr=3, len=4, last_be=0x0F, out_ready=1 -> st_off 0,1,2,3 on consecutive cycles; out_be FF,FF,FF,0F; out_last on the 4th beat; done in that pop cycle.
  - len=0 -> st_en never asserts; done pulses one cycle after accept.
  - len=256, out_ready toggling 1,0,0,1,... -> exactly 256 beats in offset order; st_off max 255; FIFO never overflows.
  - out_ready=0 for 10 cycles after accept with len=8 -> at most 2 reads issue, then stall; all 8 beats arrive intact after release.
  - rst_n pulsed low in RUN with len=16 -> outputs reset immediately; a new request then completes normally.
  - Back-to-back requests (addr 1 len 2, then addr 2 len 1) -> second accepted the cycle after the first done; no beat overlap.

Source files
------------

// File: rtl/mask_pkg.sv
// Shared types and constants for the mask store sequencer and its beat FIFO.
package mask_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/mask_beat_fifo.sv
// Small beat FIFO holding read data with its byte enable and last tag.
module mask_beat_fifo
  import mask_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [BE_WIDTH-1:0]   push_be,
  input  logic                  push_last,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [BE_WIDTH-1:0]   head_be,
  output logic                  head_last
);

  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [BE_WIDTH-1:0]   be_mem   [FIFO_DEPTH];
  logic                  last_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign empty = (count_reg == '0);

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign head_data = data_mem[rd_ptr_reg];
  assign head_be   = be_mem[rd_ptr_reg];
  assign head_last = last_mem[rd_ptr_reg];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        be_mem[i]   <= '0;
        last_mem[i] <= 1'b0;
      end
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        data_mem[wr_ptr_reg] <= push_data;
        be_mem[wr_ptr_reg]   <= push_be;
        last_mem[wr_ptr_reg] <= push_last;
        wr_ptr_reg           <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/mask_st_seq.sv
// Streams one mask register out of the mask file store port as a sequence of
// beats, with back-pressure from the consumer and a done pulse per request.
module mask_st_seq
  import mask_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int OFF_BITS   = 8,
  localparam int DW_B      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [OFF_BITS:0]     req_len,
  input  logic [DW_B-1:0]       req_last_be,
  output logic [DW_B-1:0]       st_en,
  output logic [ADDR_WIDTH-1:0] st_addr,
  output logic [OFF_BITS-1:0]   st_off,
  input  logic [DATA_WIDTH-1:0] st_data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DW_B-1:0]       out_be,
  output logic                  out_last,
  output logic                  done
);

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [OFF_BITS:0]     len_reg;
  logic [DW_B-1:0]       last_be_reg;
  logic [OFF_BITS-1:0]   off_reg;
  logic                  inflight_reg;
  logic [DW_B-1:0]       inflight_be_reg;
  logic                  inflight_last_reg;
  logic                  zero_done_reg;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [2:0]            occupancy;
  logic                  pop;
  logic                  issue;
  logic                  final_beat;
  logic [DW_B-1:0]       issue_be;

  assign req_ready  = (state_reg == IDLE);
  assign out_valid  = !fifo_empty;
  assign pop        = out_valid && out_ready;
  assign final_beat = (({1'b0, off_reg} + (OFF_BITS + 1)'(1)) == len_reg);

  // Occupancy counts FIFO entries plus the read in flight; a beat leaving this
  // cycle frees a slot, which keeps one beat per cycle with out_ready high.
  assign occupancy = {1'b0, fifo_full, !fifo_full && !fifo_empty} + 3'(inflight_reg);
  assign issue     = (state_reg == RUN) && (occupancy < (3'(FIFO_DEPTH) + 3'(pop)));

  // A zero last-beat enable would suppress the read, so widen it to all lanes.
  assign issue_be = !final_beat          ? '1 :
                    (last_be_reg == '0)  ? '1 : last_be_reg;

  assign st_en   = issue ? issue_be : '0;
  assign st_addr = issue ? addr_reg : '0;
  assign st_off  = issue ? off_reg  : '0;

  assign done = zero_done_reg || (pop && out_last && (state_reg == DRAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      len_reg           <= '0;
      last_be_reg       <= '0;
      off_reg           <= '0;
      inflight_reg      <= 1'b0;
      inflight_be_reg   <= '0;
      inflight_last_reg <= 1'b0;
      zero_done_reg     <= 1'b0;
    end else begin
      zero_done_reg     <= 1'b0;
      inflight_reg      <= issue;
      inflight_be_reg   <= issue_be;
      inflight_last_reg <= issue && final_beat;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            if (req_len == '0) begin
              zero_done_reg <= 1'b1;
            end else begin
              addr_reg    <= req_addr;
              len_reg     <= req_len;
              last_be_reg <= req_last_be;
              off_reg     <= '0;
              state_reg   <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            off_reg <= off_reg + OFF_BITS'(1);
            if (final_beat) state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  mask_beat_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (DW_B)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_reg),
    .push_data (st_data_out),
    .push_be   (inflight_be_reg),
    .push_last (inflight_last_reg),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (out_data),
    .head_be   (out_be),
    .head_last (out_last)
  );

endmodule

// File: tb/tb_mask_st_seq.sv
// Scoreboard bench for mask_st_seq: a mask-file model answers reads, and
// expected reads and beats are queued when each request is driven.
module tb_mask_st_seq;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int OB = 8;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [OB:0]   req_len;
  logic [BW-1:0] req_last_be;
  logic [BW-1:0] st_en;
  logic [AW-1:0] st_addr;
  logic [OB-1:0] st_off;
  logic [DW-1:0] st_data_out;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [BW-1:0] out_be;
  logic          out_last;
  logic          done;

  always #5 clk = ~clk;

  mask_st_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFF_BITS(OB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_last_be(req_last_be),
    .st_en(st_en), .st_addr(st_addr), .st_off(st_off), .st_data_out(st_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_be(out_be), .out_last(out_last), .done(done)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic          last;
  } beat_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [OB-1:0] off;
    logic [BW-1:0] en;
  } iss_t;

  beat_t beat_q[$];
  iss_t  iss_q[$];
  int    iss_cyc[$];
  int    pop_cyc[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int iss_total = 0;
  int pop_total = 0;
  int outstanding = 0;
  int max_off = 0;
  int ready_mode = 0;
  int ready_phase = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a, input logic [OB-1:0] o);
    return {8'(a), 8'(o), ~(8'(a)), ~o, 32'hC0DE_0000 | (32'(o) * 32'd7)};
  endfunction

  // Mask file model: data appears one cycle after the read enable, garbage otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (st_en != '0) st_data_out <= mem_word(st_addr, st_off);
    else             st_data_out <= {$urandom, $urandom};
  end

  // Consumer back-pressure: 0 = always ready, 1 = 1,0,0 repeating, 2 = stalled.
  always @(posedge clk) begin
    #1;
    ready_phase = ready_phase + 1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((ready_phase % 3) == 0);
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        pop_total++;
        outstanding--;
        pop_cyc.push_back(cyc);
        if (beat_q.size() == 0) begin
          check("extra_beat", 64'(beat_q.size()), 64'd1);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          check("out_data", out_data, b.data);
          check("out_be", 64'(out_be), 64'(b.be));
          check("out_last", 64'(out_last), 64'(b.last));
          check("done_on_pop", 64'(done), 64'(b.last));
        end
      end
      if (st_en != '0) begin
        iss_total++;
        outstanding++;
        iss_cyc.push_back(cyc);
        check("outstanding_le2", 64'(outstanding <= 2), 64'd1);
        if (int'(st_off) > max_off) max_off = int'(st_off);
        if (iss_q.size() == 0) begin
          check("extra_read", 64'(iss_q.size()), 64'd1);
        end else begin
          iss_t e;
          e = iss_q.pop_front();
          check("st_addr", 64'(st_addr), 64'(e.addr));
          check("st_off", 64'(st_off), 64'(e.off));
          check("st_en", 64'(st_en), 64'(e.en));
        end
      end
    end
  end

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [AW-1:0] a, input int len, input logic [BW-1:0] lbe);
    for (int i = 0; i < len; i++) begin
      iss_t  e;
      beat_t b;
      logic [BW-1:0] en;
      en = (i == len - 1) ? ((lbe == '0) ? {BW{1'b1}} : lbe) : {BW{1'b1}};
      e.addr = a; e.off = OB'(i); e.en = en;
      b.data = mem_word(a, OB'(i)); b.be = en; b.last = (i == len - 1);
      iss_q.push_back(e);
      beat_q.push_back(b);
    end
    exp_done++;
    req_addr    = a;
    req_len     = (OB + 1)'(len);
    req_last_be = lbe;
    req_valid   = 1'b1;
    @(negedge clk);
    check("req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    $display("request addr=%0d len=%0d last_be=%h accepted at cycle %0d", a, len, lbe, cyc);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt < exp_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(done_cnt >= exp_done), 64'd1);
    @(posedge clk);
    #1;
    $display("request drained (%s) at cycle %0d, beats so far %0d", tag, cyc, pop_total);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_st_en"}, 64'(st_en), 64'd0);
    check({tag, "_out_data"}, out_data, 64'd0);
    check({tag, "_out_be"}, 64'(out_be), 64'd0);
    check({tag, "_out_last"}, 64'(out_last), 64'd0);
    check({tag, "_st_addr"}, 64'(st_addr), 64'd0);
    check({tag, "_st_off"}, 64'(st_off), 64'd0);
  endtask

  initial begin
    int p0, i0, d0, n;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; req_last_be = '0;
    out_ready = 1'b1; st_data_out = '0;
    #2;
    check_reset_outputs("rst_low");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_rel");
    check("rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // addr 3, len 4, last_be 0F, always ready: latency and one beat per cycle
    iss_cyc.delete(); pop_cyc.delete();
    send(3, 4, 8'h0F);
    @(negedge clk); check("lat_c1_valid", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_c2_valid", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_c3_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    wait_done("len4_done", 50);
    check("len4_reads", 64'(iss_cyc.size()), 64'd4);
    check("len4_beats", 64'(pop_cyc.size()), 64'd4);
    for (int i = 1; i < 4 && i < iss_cyc.size(); i++)
      check("len4_read_gap", 64'(iss_cyc[i] - iss_cyc[i-1]), 64'd1);
    for (int i = 1; i < 4 && i < pop_cyc.size(); i++)
      check("len4_beat_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);

    // len 0: no reads, done exactly one cycle after accept
    i0 = iss_total;
    send(4, 0, 8'h00);
    @(negedge clk); check("len0_done_pulse", 64'(done), 64'd1);
    @(negedge clk); check("len0_done_low", 64'(done), 64'd0);
    check("len0_no_reads", 64'(iss_total - i0), 64'd0);
    @(posedge clk); #1;

    // len 256 with 1,0,0 back-pressure: full offset range without wrap
    ready_mode = 1; max_off = 0; p0 = pop_total; i0 = iss_total;
    send(5, 256, 8'h81);
    wait_done("len256_done", 3000);
    check("len256_beats", 64'(pop_total - p0), 64'd256);
    check("len256_reads", 64'(iss_total - i0), 64'd256);
    check("len256_max_off", 64'(max_off), 64'd255);

    // len 8 with consumer stalled for 10 cycles
    ready_mode = 2;
    @(posedge clk); #1;
    p0 = pop_total; i0 = iss_total;
    send(6, 8, 8'hF0);
    repeat (10) @(negedge clk);
    n = iss_total - i0;
    check("stall_reads_le2", 64'(n <= 2 && n > 0), 64'd1);
    check("stall_no_beats", 64'(pop_total - p0), 64'd0);
    ready_mode = 0;
    @(posedge clk); #1;
    wait_done("len8_done", 100);
    check("len8_beats", 64'(pop_total - p0), 64'd8);

    // reset in the middle of a len 16 request
    send(7, 16, 8'h33);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    beat_q.delete(); iss_q.delete(); outstanding = 0; exp_done--;
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    @(posedge clk); #1;
    p0 = pop_total;
    send(9, 5, 8'h00);
    wait_done("post_rst_done", 100);
    check("post_rst_beats", 64'(pop_total - p0), 64'd5);

    // back-to-back: second request accepted the cycle after the first done
    send(1, 2, 8'h03);
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done", 64'(done), 64'd1);
    @(posedge clk); #1;
    send(2, 1, 8'h01);
    wait_done("b2b_second_done", 50);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("end_done_total", 64'(done_cnt), 64'(exp_done));
    check("end_beats_left", 64'(beat_q.size()), 64'd0);
    check("end_reads_left", 64'(iss_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got cycle %0d required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
